// File: rtl/hsid_x_result_writer.sv
// HSID result writer: captures min/max MSE results and stores them as a word record via an OBI master.
// Optional status word (cycle count + 16'hC0DE tag) enabled by defining HSID_X_RESULT_WR_STATUS_EN.
module hsid_x_result_writer #(
   parameter int unsigned WORD_WIDTH        = 32,
   parameter int unsigned HSP_LIBRARY_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WORD_WIDTH-1:0]        base_addr,
   input  logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
   input  logic [WORD_WIDTH-1:0]        mse_min_value,
   input  logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
   input  logic [WORD_WIDTH-1:0]        mse_max_value,
   output logic                         obi_req,
   output logic [WORD_WIDTH-1:0]        obi_addr,
   output logic                         obi_we,
   output logic [3:0]                   obi_be,
   output logic [WORD_WIDTH-1:0]        obi_wdata,
   input  logic                         obi_gnt,
   input  logic                         obi_rvalid,
   output logic                         idle,
   output logic                         done,
   output logic                         error
);

`ifdef HSID_X_RESULT_WR_STATUS_EN
   localparam int unsigned NWORDS = 5;
`else
   localparam int unsigned NWORDS = 4;
`endif
   localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e                         state_q, state_d;
   logic [2:0]                     idx_q, idx_d;
   logic [WORD_WIDTH-1:0]          base_q;
   logic [HSP_LIBRARY_WIDTH-1:0]   min_ref_q, max_ref_q;
   logic [WORD_WIDTH-1:0]          min_val_q, max_val_q;
   logic                           err_q;
   logic                           start_ok, start_bad, last;
   logic [WORD_WIDTH-1:0]          word;

   assign start_ok  = start && (state_q == S_IDLE) && (base_addr[1:0] == 2'b00);
   assign start_bad = start && (state_q == S_IDLE) && (base_addr[1:0] != 2'b00);
   assign last      = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // A grant that arrives together with its response completes the word without visiting WAIT.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_REQ;
               idx_d   = '0;
            end
         end
         S_REQ: begin
            if (obi_gnt) begin
               if (obi_rvalid) begin
                  if (last) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_REQ;
                     idx_d   = idx_q + 3'd1;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (obi_rvalid) begin
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
                  idx_d   = idx_q + 3'd1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q    <= '0;
         min_ref_q <= '0;
         min_val_q <= '0;
         max_ref_q <= '0;
         max_val_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= start_bad;
         if (start_ok) begin
            base_q    <= base_addr;
            min_ref_q <= mse_min_ref;
            min_val_q <= mse_min_value;
            max_ref_q <= mse_max_ref;
            max_val_q <= mse_max_value;
         end
      end
   end

`ifdef HSID_X_RESULT_WR_STATUS_EN
   logic [15:0] cnt_q;
   logic        cnt_run_q;

   // Counts from the start cycle (cycle 0) and freezes on the grant of word 3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         cnt_run_q <= 1'b0;
      end else if (start_ok) begin
         cnt_q     <= 16'd1;
         cnt_run_q <= 1'b1;
      end else if (cnt_run_q) begin
         if ((state_q == S_REQ) && obi_gnt && (idx_q == 3'd3)) begin
            cnt_run_q <= 1'b0;
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end
`endif

   always_comb begin
      word = '0;
      unique case (idx_q)
         3'd0:    word = WORD_WIDTH'(min_ref_q);
         3'd1:    word = min_val_q;
         3'd2:    word = WORD_WIDTH'(max_ref_q);
         3'd3:    word = max_val_q;
`ifdef HSID_X_RESULT_WR_STATUS_EN
         3'd4:    word = WORD_WIDTH'({16'hC0DE, cnt_q});
`endif
         default: word = '0;
      endcase
   end

   always_comb begin
      obi_req   = (state_q == S_REQ);
      obi_addr  = obi_req ? (base_q + WORD_WIDTH'({idx_q, 2'b00})) : '0;
      obi_wdata = obi_req ? word : '0;
      obi_we    = obi_req;
      obi_be    = obi_req ? 4'hF : 4'h0;
      idle      = (state_q == S_IDLE);
      done      = (state_q == S_DONE);
      error     = err_q;
   end

endmodule

// File: tb/tb_hsid_x_result_writer.sv
// Directed bench for hsid_x_result_writer with a programmable-latency OBI memory responder.
// Build with HSID_X_RESULT_WR_STATUS_EN defined to cover the status-word variant.
module tb_hsid_x_result_writer;

`ifdef HSID_X_RESULT_WR_STATUS_EN
   localparam int NW = 5;
`else
   localparam int NW = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  mse_min_ref = '0, mse_max_ref = '0;
   logic [31:0] mse_min_value = '0, mse_max_value = '0;
   logic        obi_req, obi_we, obi_gnt, obi_rvalid, idle, done, error;
   logic [31:0] obi_addr, obi_wdata;
   logic [3:0]  obi_be;

   logic        zw = 1'b1;
   logic        gnt_r = 1'b0, rv_r = 1'b0;
   int          gnt_dly = 0, rv_dly = 1;

   int          cyc = 0;
   int          n_vec = 0, n_err = 0;
   int          done_cnt = 0, err_cnt = 0, req_seen = 0;
   logic [31:0] wa[$], wd[$];
   int          t0, lat;
   bit          found;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign obi_gnt    = zw ? 1'b1 : gnt_r;
   assign obi_rvalid = zw ? (obi_req & obi_gnt) : rv_r;

   hsid_x_result_writer #(.WORD_WIDTH(32), .HSP_LIBRARY_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .mse_min_ref(mse_min_ref), .mse_min_value(mse_min_value),
      .mse_max_ref(mse_max_ref), .mse_max_value(mse_max_value),
      .obi_req(obi_req), .obi_addr(obi_addr), .obi_we(obi_we), .obi_be(obi_be),
      .obi_wdata(obi_wdata), .obi_gnt(obi_gnt), .obi_rvalid(obi_rvalid),
      .idle(idle), .done(done), .error(error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory responder: grant after gnt_dly stalled cycles, response rv_dly cycles after grant.
   initial forever begin
      @(negedge clk);
      gnt_r = 1'b0;
      rv_r  = 1'b0;
      if (!zw && obi_req) begin
         repeat (gnt_dly) @(negedge clk);
         gnt_r = 1'b1;
         @(negedge clk);
         gnt_r = 1'b0;
         repeat (rv_dly - 1) @(negedge clk);
         rv_r = 1'b1;
         @(negedge clk);
         rv_r = 1'b0;
      end
   end

   // Bus monitor, sampled late in each cycle.
   initial begin
      bit          prev_stall;
      logic [31:0] p_addr, p_data;
      prev_stall = 1'b0;
      p_addr = '0;
      p_data = '0;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n) begin
            if (obi_req) begin
               req_seen++;
               chk("we", {31'b0, obi_we}, 32'd1);
               chk("be", {28'b0, obi_be}, 32'hF);
               if (prev_stall) begin
                  chk("addr_stable", obi_addr, p_addr);
                  chk("wdata_stable", obi_wdata, p_data);
               end
               if (obi_gnt) begin
                  wa.push_back(obi_addr);
                  wd.push_back(obi_wdata);
               end
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
            prev_stall = obi_req && !obi_gnt;
            p_addr = obi_addr;
            p_data = obi_wdata;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic clear_log();
      wa.delete();
      wd.delete();
      done_cnt = 0;
      err_cnt  = 0;
      req_seen = 0;
   endtask

   task automatic pulse_start(input logic [31:0] b, input logic [7:0] mnr, input logic [31:0] mnv,
                              input logic [7:0] mxr, input logic [31:0] mxv);
      @(negedge clk);
      base_addr = b;
      mse_min_ref = mnr;
      mse_min_value = mnv;
      mse_max_ref = mxr;
      mse_max_value = mxv;
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         #3;
         if (done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      lat = cyc - t0;
      chk("done_seen", {31'b0, found}, 32'd1);
   endtask

   task automatic check_log(input string tag, input logic [31:0] b, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                            input bit full_cnt, input logic [15:0] exp_cnt);
      logic [31:0] ew[4];
      ew[0] = w0; ew[1] = w1; ew[2] = w2; ew[3] = w3;
      chk({tag, "_nwrites"}, 32'(wa.size()), 32'(NW));
      for (int i = 0; i < 4; i++) begin
         if (i < wa.size()) begin
            chk($sformatf("%s_addr%0d", tag, i), wa[i], b + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wd[i], ew[i]);
         end
      end
`ifdef HSID_X_RESULT_WR_STATUS_EN
      if (wa.size() > 4) begin
         chk({tag, "_addr4"}, wa[4], b + 32'h10);
         chk({tag, "_tag4"}, {16'h0, wd[4][31:16]}, 32'h0000C0DE);
         if (full_cnt) chk({tag, "_cnt4"}, {16'h0, wd[4][15:0]}, {16'h0, exp_cnt});
      end
`endif
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_idle", {31'b0, idle}, 32'd1);
      chk("rst_req", {31'b0, obi_req}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_error", {31'b0, error}, 32'd0);
      chk("rst_addr", obi_addr, 32'd0);
      chk("rst_wdata", obi_wdata, 32'd0);
      chk("rst_we_be", {27'b0, obi_we, obi_be}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait memory
      clear_log();
      zw = 1'b1;
      pulse_start(32'h1000, 8'd3, 32'h10, 8'd7, 32'h2000);
      wait_done(50);
      chk("zw_latency", 32'(lat), 32'(NW + 1));
      @(negedge clk);
      #3;
      chk("zw_idle_after", {31'b0, idle}, 32'd1);
      chk("zw_done_low", {31'b0, done}, 32'd0);
      check_log("zw", 32'h1000, 32'd3, 32'h10, 32'd7, 32'h2000, 1'b1, 16'd4);

      // Address wrap at top of the address space
      clear_log();
      pulse_start(32'hFFFF_FFF8, 8'hFF, 32'h0, 8'h80, 32'h8000_0001);
      wait_done(50);
      @(negedge clk);
      check_log("wrap", 32'hFFFF_FFF8, 32'hFF, 32'h0, 32'h80, 32'h8000_0001, 1'b1, 16'd4);
      chk("wrap_addr2", (wa.size() > 2) ? wa[2] : 32'hDEAD_0000, 32'h0000_0000);

      // Grant delayed 3 cycles, response 2 cycles after grant
      clear_log();
      zw = 1'b0;
      gnt_dly = 3;
      rv_dly = 2;
      pulse_start(32'h2000, 8'h5A, 32'hDEAD_BEEF, 8'hFF, 32'h1234_5678);
      wait_done(300);
      repeat (3) @(negedge clk);
      check_log("slow", 32'h2000, 32'h5A, 32'hDEAD_BEEF, 32'hFF, 32'h1234_5678, 1'b0, 16'd0);

      // Misaligned base address
      clear_log();
      @(negedge clk);
      base_addr = 32'h1002;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #3;
      chk("mis_error_pulse", {31'b0, error}, 32'd1);
      chk("mis_idle", {31'b0, idle}, 32'd1);
      @(negedge clk);
      #3;
      chk("mis_error_low", {31'b0, error}, 32'd0);
      repeat (5) @(negedge clk);
      #3;
      chk("mis_no_req", 32'(req_seen), 32'd0);
      chk("mis_err_count", 32'(err_cnt), 32'd1);
      chk("mis_idle_after", {31'b0, idle}, 32'd1);

      // Restart during WAIT of word 1 and input changes after capture are ignored
      clear_log();
      @(negedge clk);
      pulse_start(32'h3000, 8'h01, 32'h0000_0100, 8'h02, 32'hFFFF_FFFF);
      base_addr = 32'h5000;
      mse_min_ref = 8'h44;
      mse_min_value = 32'h4444_4444;
      mse_max_ref = 8'h55;
      mse_max_value = 32'h5555_5555;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #3;
         if (wa.size() == 2 && !obi_req) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("restart_reach_wait1", {31'b0, found}, 32'd1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(300);
      repeat (3) @(negedge clk);
      check_log("restart", 32'h3000, 32'h01, 32'h0000_0100, 32'h02, 32'hFFFF_FFFF, 1'b0, 16'd0);

      // Asynchronous reset during WAIT of word 2
      clear_log();
      @(negedge clk);
      pulse_start(32'h6000, 8'h09, 32'h9, 8'h0A, 32'hA);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #3;
         if (wa.size() == 3 && !obi_req) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rst_reach_wait2", {31'b0, found}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'b0, obi_req}, 32'd0);
      chk("midrst_idle", {31'b0, idle}, 32'd1);
      chk("midrst_done", {31'b0, done}, 32'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      pulse_start(32'h7000, 8'h11, 32'hAAAA_5555, 8'h22, 32'h0BAD_F00D);
      wait_done(300);
      repeat (3) @(negedge clk);
      check_log("after_rst", 32'h7000, 32'h11, 32'hAAAA_5555, 32'h22, 32'h0BAD_F00D, 1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
